uart_rx: RTL and testbench
==========================

# uart_rx

Serial-to-parallel receive stage of the UART. Consumes the already-synchronized RX line from the upstream two-flop `sync` stage and detects start bits. Samples each bit at its centre, checks the stop bit (and optionally parity), and presents each received byte on a valid/ready interface to the downstream consumer. Framing and overrun conditions are reported as one-cycle pulses.

## Interface
- `CLKS_PER_BIT`, default 868: `i_clk` cycles per bit (100 MHz / 115200); must be ≥ 4.
- `DATA_BITS`, default 8: data bits per frame, 5–8.
- `i_clk`  in  1  system clock; all logic on the rising edge.
- `i_rst_n`  in  1  reset, asynchronous and active-low.
- `i_rx`  in  1  synchronized serial line; idles high.
- `o_data`  out  DATA_BITS  received byte, LSB = first bit on the wire.
- `o_valid`  out  1  `o_data` holds an unconsumed byte.
- `i_ready`  in  1  consumer accepts `o_data` when high together with `o_valid`.
- `o_busy`  out  1  FSM is not in IDLE.
- `o_frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `o_parity_err`  out  1  one-cycle pulse: parity mismatch; constant 0 when parity is compiled out.
- `o_overrun`  out  1  one-cycle pulse: a good byte was dropped because `o_valid` was still high.

## Operation
- States: IDLE, START, DATA, PARITY (compiled in with parity only), STOP, RECOVER.
- Bit counter width: `$clog2(CLKS_PER_BIT)`. Bit index width: `$clog2(DATA_BITS+1)`.
- IDLE: `i_rx`==0 → START, counter cleared.
- START: at count `CLKS_PER_BIT/2 - 1` (integer division) sample `i_rx`.
  - 1 → glitch; return to IDLE with no flags.
  - 0 → DATA; counter and index cleared.
- DATA: on each count `CLKS_PER_BIT - 1`, sample `i_rx` and shift it in at the MSB of the shift register (shift right).
  - After `DATA_BITS` samples → PARITY if parity is compiled in, else STOP.
- PARITY: sample one bit after `CLKS_PER_BIT` clocks; record mismatch against even parity of the data bits → STOP.
- STOP: sample after `CLKS_PER_BIT` clocks.
  - 1 and no parity error → deliver the byte; → IDLE.
  - 1 with parity error → `o_parity_err` pulse, byte discarded; → IDLE.
  - 0 → `o_frame_err` pulse, byte discarded; → RECOVER. Parity error is also pulsed if it was set.
- RECOVER: wait for `i_rx`==1, then → IDLE. A break condition therefore produces exactly one `o_frame_err`.
- Delivery: if `o_valid`==0, or `o_valid && i_ready` in the same cycle, load `o_data` and set `o_valid`. Otherwise pulse `o_overrun`, drop the new byte, and keep the held byte.
- Handshake: `o_valid` clears on a rising edge where `o_valid && i_ready`. `o_data` is stable while `o_valid`==1.

## Timing
- Reset asserted: state IDLE; `o_data`=0; `o_valid`, `o_busy` and all error pulses = 0; counters cleared. Takes effect immediately and aborts any frame in flight.
- Reset release: the first possible start detection is one clock after `i_rst_n` rises.
- Latency: `o_valid` rises one clock after the stop-bit sample, i.e. `CLKS_PER_BIT/2 + (DATA_BITS+1[+1 parity])·CLKS_PER_BIT + 1` clocks after the cycle `i_rx` is first seen low.
- Returning to IDLE at mid-stop-bit allows back-to-back frames with zero idle time and up to ~±4 % baud mismatch.
- `o_busy` is high from the cycle after start detection until the FSM re-enters IDLE.

## Configuration
- `UART_RX_PARITY_EN` defined: PARITY state present; one even-parity bit expected between data and stop; `o_parity_err` is live.
- `UART_RX_PARITY_EN` undefined: frame is start + data + stop only; `o_parity_err` tied to 0; no parity logic is generated.

## Structure
- Shared `uart_pkg`:
  - RX state enum typedef.
  - Default `CLKS_PER_BIT` localparam.
  - Function computing even parity.
- One sub-module is natural: `uart_rx_bit_timer`. It holds the per-bit counter and emits `half_tick` and `bit_tick`, with a `clear` input driven by the FSM.

## Test plan
Bench uses `CLKS_PER_BIT`=16, `DATA_BITS`=8.
- Send 0xA5, `i_ready`=1 → `o_data`=0xA5 with a one-cycle `o_valid`, exactly 153 clocks after the falling edge (8 + 9·16 + 1); no error flags.
- 4-clock low glitch on idle line → no `o_valid` and no flags; `o_busy` high for ≤ 8 clocks, then low.
- Send 0x3C with stop bit forced low, then hold line low for 40 bits → exactly one `o_frame_err`, no `o_valid`; after line returns high, 0x81 is received correctly.
- `i_ready`=0; send 0x11 then 0x22 back-to-back → `o_data` stays 0x11, one `o_overrun` pulse; raise `i_ready` → 0x11 consumed, `o_valid` drops.
- Assert `i_rst_n`=0 mid-DATA of 0xFF, release, send 0x5A → only 0x5A is delivered; all outputs 0 during reset.
- With `UART_RX_PARITY_EN`: send 0x07 with parity bit 0 (wrong) → `o_parity_err` pulse, no `o_valid`; send 0x07 with parity bit 1 → 0x07 delivered.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: RX state encoding, default bit timing, even-parity helper.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int UART_CLKS_PER_BIT_DFLT = 868;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_RX_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP,
    RX_RECOVER
  } rx_state_e;

  // Narrower frames are zero-extended by the caller, which leaves the XOR unchanged.
  function automatic logic even_parity(input logic [7:0] i_bits);
    return ^i_bits;
  endfunction

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Per-bit clock counter for the UART receiver: flags the half-bit point and the
// end of each bit period; the FSM restarts it through i_clear.
module uart_rx_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DFLT
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  output logic o_half_tick,
  output logic o_bit_tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear || (r_cnt == LAST_CNT)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_half_tick = (r_cnt == HALF_CNT);
  assign o_bit_tick  = (r_cnt == LAST_CNT);

endmodule

// File: rtl/uart_rx.sv
// UART receive stage: centre-samples each bit, checks stop (and even parity when
// UART_RX_PARITY_EN is defined) and hands bytes out on a valid/ready interface.
//
// state      | meaning
// RX_IDLE    | line idle, waiting for a low level
// RX_START   | confirming start bit at its centre
// RX_DATA    | sampling DATA_BITS data bits, LSB first
// RX_PARITY  | sampling the even-parity bit (parity builds only)
// RX_STOP    | sampling the stop bit, delivering or flagging the frame
// RX_RECOVER | after a framing error, waiting for the line to go high
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DFLT,
  parameter int DATA_BITS    = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_busy,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_overrun
);

  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  rx_state_e r_state;
  rx_state_e w_state_nxt;

  logic w_clear;
  logic w_half_tick;
  logic w_bit_tick;
  logic w_idx_clr;
  logic w_shift_en;
  logic w_deliver;
  logic w_frame_fail;
  logic w_par_err;

  logic [IW-1:0]        r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_frame_err;
  logic                 r_overrun;

`ifdef UART_RX_PARITY_EN
  logic w_par_sample;
  logic w_par_fail;
  logic r_par_err;
  logic r_parity_err;
  assign w_par_err = r_par_err;
`else
  assign w_par_err = 1'b0;
`endif

  uart_rx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clear    (w_clear),
    .o_half_tick(w_half_tick),
    .o_bit_tick (w_bit_tick)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= RX_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_clear      = 1'b0;
    w_idx_clr    = 1'b0;
    w_shift_en   = 1'b0;
    w_deliver    = 1'b0;
    w_frame_fail = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_sample = 1'b0;
    w_par_fail   = 1'b0;
`endif
    case (r_state)
      RX_IDLE: begin
        w_clear = 1'b1;
        if (!i_rx) begin
          w_state_nxt = RX_START;
        end
      end
      RX_START: begin
        if (w_half_tick) begin
          w_clear     = 1'b1;
          w_idx_clr   = 1'b1;
          w_state_nxt = i_rx ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (w_bit_tick) begin
          w_shift_en = 1'b1;
          if (r_bit_idx == LAST_IDX) begin
            w_clear = 1'b1;
`ifdef UART_RX_PARITY_EN
            w_state_nxt = RX_PARITY;
`else
            w_state_nxt = RX_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      RX_PARITY: begin
        if (w_bit_tick) begin
          w_par_sample = 1'b1;
          w_state_nxt  = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        if (w_bit_tick) begin
`ifdef UART_RX_PARITY_EN
          w_par_fail = w_par_err;
`endif
          if (i_rx) begin
            w_deliver   = !w_par_err;
            w_state_nxt = RX_IDLE;
          end else begin
            w_frame_fail = 1'b1;
            w_state_nxt  = RX_RECOVER;
          end
        end
      end
      RX_RECOVER: begin
        if (i_rx) begin
          w_state_nxt = RX_IDLE;
        end
      end
      default: begin
        w_state_nxt = RX_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_frame_fail;
      r_overrun   <= 1'b0;
      if (w_idx_clr) begin
        r_bit_idx <= '0;
      end else if (w_shift_en) begin
        r_bit_idx <= r_bit_idx + IW'(1);
      end
      if (w_shift_en) begin
        r_shift <= {i_rx, r_shift[DATA_BITS-1:1]};
      end
      // A byte landing in the same cycle the held one is consumed is accepted.
      if (w_deliver) begin
        if (!r_valid || i_ready) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_par_err    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= w_par_fail;
      if (w_idx_clr) begin
        r_par_err <= 1'b0;
      end else if (w_par_sample) begin
        r_par_err <= (i_rx != even_parity(8'(r_shift)));
      end
    end
  end

  assign o_parity_err = r_parity_err;
`else
  assign o_parity_err = 1'b0;
`endif

  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_busy      = (r_state != RX_IDLE);
  assign o_frame_err = r_frame_err;
  assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx (CLKS_PER_BIT=16, DATA_BITS=8); expected bytes
// go into a scoreboard queue when sent and are popped on each valid/ready handshake.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       busy;
  logic       ferr;
  logic       perr;
  logic       ovr;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  int   n_valid_rise = 0;
  int   n_ferr = 0;
  int   n_perr = 0;
  int   n_ovr  = 0;
  logic prev_valid = 1'b0;

  always #5 clk = ~clk;

  uart_rx #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (8)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_rx        (rx),
    .o_data      (data),
    .o_valid     (valid),
    .i_ready     (ready),
    .o_busy      (busy),
    .o_frame_err (ferr),
    .o_parity_err(perr),
    .o_overrun   (ovr)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor: pulse counters and scoreboard pop on each handshake.
  always @(negedge clk) begin
    if (ferr) n_ferr++;
    if (perr) n_perr++;
    if (ovr)  n_ovr++;
    if (valid && !prev_valid) n_valid_rise++;
    prev_valid = valid;
    if (valid && ready) begin
      check_val("sb_has_exp", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check_val("sb_data", data, exp_q.pop_front());
    end
  end

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input logic use_par, input logic par_bit);
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(d[i], CPB);
    if (use_par) hold(par_bit, CPB);
    hold(stop_bit, CPB);
  endtask

  task automatic check_reset_outs(input string pfx);
    check_val({pfx, "_data"},  data,  0);
    check_val({pfx, "_valid"}, valid, 0);
    check_val({pfx, "_busy"},  busy,  0);
    check_val({pfx, "_ferr"},  ferr,  0);
    check_val({pfx, "_perr"},  perr,  0);
    check_val({pfx, "_ovr"},   ovr,   0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bc, v0, f0, p0, o0;
    rst_n = 1'b0;
    rx    = 1'b1;
    ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outs("por");
    rst_n = 1'b1;
    hold(1'b1, 4);

    // 0xA5 with latency measurement from the first low drive
    v0 = n_valid_rise; f0 = n_ferr; p0 = n_perr; o0 = n_ovr;
    exp_q.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
      begin
        lat = 0;
        do begin
          @(posedge clk);
          #1;
          lat++;
        end while (!valid && lat < 400);
        check_val("a5_latency", lat, 153);
        check_val("a5_data", data, 8'hA5);
        @(posedge clk);
        #1;
        check_val("a5_valid_1cyc", valid, 0);
      end
    join
    check_val("a5_vrise", n_valid_rise - v0, 1);
    check_val("a5_flags", (n_ferr - f0) + (n_perr - p0) + (n_ovr - o0), 0);

    // 4-clock glitch on idle line
    v0 = n_valid_rise; f0 = n_ferr; p0 = n_perr; o0 = n_ovr;
    bc = 0;
    for (int i = 0; i < 30; i++) begin
      rx = (i >= 4);
      @(posedge clk);
      #1;
      if (busy) bc++;
    end
    check_val("glitch_busy_le8", (bc <= 8) && (bc > 0), 1);
    check_val("glitch_busy_end", busy, 0);
    check_val("glitch_vrise", n_valid_rise - v0, 0);
    check_val("glitch_flags", (n_ferr - f0) + (n_perr - p0) + (n_ovr - o0), 0);

    // framing error followed by a long break, then a good byte
    v0 = n_valid_rise; f0 = n_ferr;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    hold(1'b0, 40 * CPB);
    check_val("brk_ferr", n_ferr - f0, 1);
    check_val("brk_vrise", n_valid_rise - v0, 0);
    check_val("brk_busy", busy, 1);
    hold(1'b1, 2 * CPB);
    check_val("brk_idle", busy, 0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0);
    hold(1'b1, 2 * CPB);
    check_val("brk_81_vrise", n_valid_rise - v0, 1);
    check_val("brk_ferr_once", n_ferr - f0, 1);

    // overrun: two back-to-back bytes with consumer stalled
    ready = 1'b0;
    o0 = n_ovr;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    hold(1'b1, 2 * CPB);
    check_val("ovr_pulse", n_ovr - o0, 1);
    check_val("ovr_data", data, 8'h11);
    check_val("ovr_valid", valid, 1);
    ready = 1'b1;
    @(posedge clk);
    #1;
    check_val("ovr_consumed", valid, 0);

    // reset in the middle of 0xFF, then 0x5A
    hold(1'b0, CPB);
    hold(1'b1, 3 * CPB);
    check_val("rst_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outs("rst_mid");
    hold(1'b1, 4);
    check_reset_outs("rst_hold");
    rst_n = 1'b1;
    hold(1'b1, CPB);
    v0 = n_valid_rise;
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    hold(1'b1, 2 * CPB);
    check_val("rst_5a_vrise", n_valid_rise - v0, 1);

`ifdef UART_RX_PARITY_EN
    v0 = n_valid_rise; p0 = n_perr;
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    hold(1'b1, 2 * CPB);
    check_val("par_bad_perr", n_perr - p0, 1);
    check_val("par_bad_vrise", n_valid_rise - v0, 0);
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    hold(1'b1, 2 * CPB);
    check_val("par_good_vrise", n_valid_rise - v0, 1);
    check_val("par_good_perr", n_perr - p0, 1);
`endif

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check_val("sb_drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
